// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU input sequencer: FSM states, ALU
// opcodes and flag bit positions.
package alu_seq_pkg;
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [1:0] OP_NOR  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  localparam int F_V = 4;
  localparam int F_C = 3;
  localparam int F_Z = 2;
  localparam int F_N = 1;
  localparam int F_P = 0;
endpackage

// File: rtl/alu_input_sequencer_rising_edge_detect.sv
// One-cycle pulse on a low-to-high transition of an already synchronised level.
// The history register resets high so a level held through reset is not an edge.
module rising_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b1;
    else       prev <= in;
  end

  assign out = in & ~prev;
endmodule

// File: rtl/alu_input_sequencer.sv
// Three-step operand/opcode entry from a shared switch bus, one settle cycle for
// the combinational ALU, then capture of its result and flags for display.
module alu_input_sequencer
  import alu_seq_pkg::*;
#(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] DataIn,
  input  logic         Load,
  input  logic         Clear,
  output logic [M-1:0] A,
  output logic [M-1:0] B,
  output logic [1:0]   OpCode,
  input  logic [M-1:0] Result,
  input  logic [4:0]   Flags,
  output logic [M-1:0] ResultReg,
  output logic [4:0]   FlagsReg,
  output logic         Valid,
  output logic [2:0]   State,
  output logic [M-1:0] Display
);
  state_t state;
  logic   load_edge;

  rising_edge_detect u_load_edge (
    .clk   (clk),
    .reset (reset),
    .in    (Load),
    .out   (load_edge)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_A;
      A         <= '0;
      B         <= '0;
      OpCode    <= OP_NOR;
      ResultReg <= '0;
      FlagsReg  <= '0;
      Valid     <= 1'b0;
    end else if (Clear) begin
      state     <= S_A;
      A         <= '0;
      B         <= '0;
      OpCode    <= OP_NOR;
      ResultReg <= '0;
      FlagsReg  <= '0;
      Valid     <= 1'b0;
    end else begin
      case (state)
        S_A: if (load_edge) begin
          A     <= DataIn;
          state <= S_B;
        end
        S_B: if (load_edge) begin
          B     <= DataIn;
          state <= S_OP;
        end
        S_OP: if (load_edge) begin
          OpCode <= DataIn[1:0];
          state  <= S_CALC;
        end
        // ALU inputs have been stable for this whole cycle; take its outputs
        S_CALC: begin
          ResultReg <= Result;
          FlagsReg  <= Flags;
          Valid     <= 1'b1;
          state     <= S_SHOW;
        end
        S_SHOW: if (load_edge) begin
          Valid <= 1'b0;
          state <= S_A;
        end
        default: state <= S_A;
      endcase
    end
  end

  assign State = state;

  always_comb begin
    Display = DataIn;
    if (state == S_CALC || state == S_SHOW) Display = ResultReg;
  end
endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench: sequencer wired to a behavioural 8-bit ALU, directed scenarios plus
// randomized operations checked against an integer-arithmetic reference.
module tb_alu_input_sequencer;
  import alu_seq_pkg::*;
  localparam int M = 8;

  logic         clk = 1'b0;
  logic         reset, Load, Clear;
  logic [M-1:0] DataIn, A, B, Result, ResultReg, Display;
  logic [1:0]   OpCode;
  logic [4:0]   Flags, FlagsReg;
  logic         Valid;
  logic [2:0]   State;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  alu_input_sequencer #(.M(M)) dut (
    .clk(clk), .reset(reset), .DataIn(DataIn), .Load(Load), .Clear(Clear),
    .A(A), .B(B), .OpCode(OpCode), .Result(Result), .Flags(Flags),
    .ResultReg(ResultReg), .FlagsReg(FlagsReg), .Valid(Valid),
    .State(State), .Display(Display)
  );

  // Behavioural ALU driven by the sequencer's registers
  logic [M:0] wide;
  always_comb begin
    Result = '0;
    Flags  = '0;
    wide   = '0;
    case (OpCode)
      OP_NOR:  Result = ~(A | B);
      OP_NAND: Result = ~(A & B);
      OP_ADD: begin
        wide = {1'b0, A} + {1'b0, B};
        Result = wide[M-1:0];
        Flags[F_C] = wide[M];
        Flags[F_V] = (A[M-1] == B[M-1]) && (Result[M-1] != A[M-1]);
      end
      default: begin
        wide = {1'b0, A} - {1'b0, B};
        Result = wide[M-1:0];
        Flags[F_C] = wide[M];
        Flags[F_V] = (A[M-1] != B[M-1]) && (Result[M-1] != A[M-1]);
      end
    endcase
    Flags[F_Z] = (Result == '0);
    Flags[F_N] = Result[M-1];
    Flags[F_P] = ~^Result;
  end

  // Reference: {V,C,Z,N,P,result} from signed/unsigned integer arithmetic
  function automatic logic [12:0] ref_alu(int a, int b, int op);
    int r, sa, sb, sr;
    logic v, c, z, n, p;
    logic [7:0] rb;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    v = 0; c = 0;
    case (op)
      0: r = (~(a | b)) & 255;
      1: r = (~(a & b)) & 255;
      2: begin r = a + b; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); r = r % 256; end
      default: begin r = a - b; c = (r < 0); sr = sa - sb; v = (sr > 127) || (sr < -128); r = (r + 256) % 256; end
    endcase
    rb = r[7:0];
    z = (r == 0);
    n = (r >= 128);
    p = ($countones(rb) % 2) == 0;
    return {v, c, z, n, p, rb};
  endfunction

  task automatic do_load_hold(input logic [7:0] d, input int n);
    DataIn = d; Load = 1'b1;
    repeat (n) @(posedge clk);
    #1 Load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [7:0] d);
    do_load_hold(d, 1);
  endtask

  task automatic test_reset;
    reset = 1'b1; Load = 1'b1; Clear = 1'b0; DataIn = 8'($urandom);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (State !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", State); end
    checks++; if (A !== 8'h00 || B !== 8'h00 || OpCode !== 2'b00) begin failures++; $display("FAIL reset_operands got=%h %h %b exp=00 00 00", A, B, OpCode); end
    checks++; if (Valid !== 1'b0 || ResultReg !== 8'h00 || FlagsReg !== 5'b0) begin failures++; $display("FAIL reset_result got=%b %h %b exp=0 00 00000", Valid, ResultReg, FlagsReg); end
    checks++; if (Display !== DataIn) begin failures++; $display("FAIL reset_display got=%h exp=%h", Display, DataIn); end
    Load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow;
    do_load(8'h7F);
    checks++; if (State !== 3'd1 || A !== 8'h7F) begin failures++; $display("FAIL add_load_a got=%0d %h exp=1 7f", State, A); end
    do_load(8'h01);
    do_load(8'h02);
    checks++; if (ResultReg !== 8'h80 || FlagsReg !== 5'b10010) begin failures++; $display("FAIL add_result got=%h %b exp=80 10010", ResultReg, FlagsReg); end
    checks++; if (Valid !== 1'b1 || State !== 3'd4) begin failures++; $display("FAIL add_valid got=%b %0d exp=1 4", Valid, State); end
    checks++; if (Display !== 8'h80) begin failures++; $display("FAIL add_display got=%h exp=80", Display); end
    do_load(8'h00);
  endtask

  task automatic test_sub_valid_timing;
    do_load(8'h05);
    do_load(8'h05);
    DataIn = 8'hFF; Load = 1'b1;  // upper bits must be ignored
    @(posedge clk); #1;
    checks++; if (Valid !== 1'b0 || State !== 3'd3 || OpCode !== 2'b11) begin failures++; $display("FAIL sub_op_edge got=%b %0d %b exp=0 3 11", Valid, State, OpCode); end
    Load = 1'b0;
    @(posedge clk); #1;
    checks++; if (Valid !== 1'b1) begin failures++; $display("FAIL sub_valid_rise got=%b exp=1", Valid); end
    checks++; if (ResultReg !== 8'h00 || FlagsReg !== 5'b00101) begin failures++; $display("FAIL sub_result got=%h %b exp=00 00101", ResultReg, FlagsReg); end
    do_load(8'h00);
  endtask

  task automatic test_nor_show_exit;
    do_load(8'hF0);
    do_load(8'h0F);
    do_load(8'h00);
    checks++; if (ResultReg !== 8'h00 || FlagsReg !== 5'b00101 || Valid !== 1'b1) begin failures++; $display("FAIL nor_result got=%h %b %b exp=00 00101 1", ResultReg, FlagsReg, Valid); end
    do_load(8'h5A);
    checks++; if (State !== 3'd0 || Valid !== 1'b0) begin failures++; $display("FAIL show_exit got=%0d %b exp=0 0", State, Valid); end
    checks++; if (ResultReg !== 8'h00 || Display !== 8'h5A) begin failures++; $display("FAIL show_exit_hold got=%h %h exp=00 5a", ResultReg, Display); end
  endtask

  task automatic test_clear;
    do_load(8'h12);
    do_load(8'h34);
    DataIn = 8'h02; Load = 1'b1; Clear = 1'b1;
    @(posedge clk); #1;
    Clear = 1'b0; Load = 1'b0;
    checks++; if (State !== 3'd0 || A !== 8'h00 || B !== 8'h00 || OpCode !== 2'b00 || Valid !== 1'b0) begin failures++; $display("FAIL clear_in_op got=%0d %h %h %b %b exp=0 00 00 00 0", State, A, B, OpCode, Valid); end
    @(posedge clk); #1;
    do_load(8'h7F);
    do_load(8'h01);
    do_load(8'h02);
    Clear = 1'b1;
    @(posedge clk); #1;
    Clear = 1'b0;
    checks++; if (State !== 3'd0 || ResultReg !== 8'h00 || FlagsReg !== 5'b0 || Valid !== 1'b0) begin failures++; $display("FAIL clear_in_show got=%0d %h %b %b exp=0 00 00000 0", State, ResultReg, FlagsReg, Valid); end
  endtask

  task automatic test_async_reset;
    do_load(8'h7F);
    do_load(8'h01);
    DataIn = 8'h02; Load = 1'b1;
    @(posedge clk); #1;
    checks++; if (State !== 3'd3) begin failures++; $display("FAIL areset_pre got=%0d exp=3", State); end
    #2 reset = 1'b1;
    #1;
    checks++; if (State !== 3'd0 || A !== 8'h00 || B !== 8'h00 || OpCode !== 2'b00 || Valid !== 1'b0) begin failures++; $display("FAIL areset_immediate got=%0d %h %h %b %b exp=0 00 00 00 0", State, A, B, OpCode, Valid); end
    @(posedge clk); #1;
    checks++; if (ResultReg !== 8'h00 || FlagsReg !== 5'b0 || Valid !== 1'b0) begin failures++; $display("FAIL areset_no_capture got=%h %b %b exp=00 00000 0", ResultReg, FlagsReg, Valid); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (State !== 3'd0) begin failures++; $display("FAIL areset_no_edge got=%0d exp=0", State); end
    Load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [7:0] a, b, d, prev_res;
    logic [12:0] exp;
    int op;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = $urandom_range(0, 3);
      d = {6'($urandom), 2'(op)};
      exp = ref_alu(a, b, op);
      do_load_hold(a, $urandom_range(1, 3));
      do_load_hold(b, $urandom_range(1, 3));
      checks++; if (State !== 3'd2 || A !== a || B !== b) begin failures++; $display("FAIL rnd_operands i=%0d got=%0d %h %h exp=2 %h %h", i, State, A, B, a, b); end
      do_load_hold(d, $urandom_range(1, 3));
      checks++; if (State !== 3'd4 || Valid !== 1'b1 || OpCode !== 2'(op)) begin failures++; $display("FAIL rnd_state i=%0d got=%0d %b %b exp=4 1 %b", i, State, Valid, OpCode, 2'(op)); end
      checks++; if (ResultReg !== exp[7:0] || FlagsReg !== exp[12:8]) begin failures++; $display("FAIL rnd_result i=%0d op=%0d a=%h b=%h got=%h %b exp=%h %b", i, op, a, b, ResultReg, FlagsReg, exp[7:0], exp[12:8]); end
      prev_res = exp[7:0];
      do_load(8'($urandom));
      checks++; if (State !== 3'd0 || Valid !== 1'b0 || ResultReg !== prev_res || Display !== DataIn) begin failures++; $display("FAIL rnd_exit i=%0d got=%0d %b %h %h exp=0 0 %h %h", i, State, Valid, ResultReg, Display, prev_res, DataIn); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_valid_timing();
    test_nor_show_exit();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
